// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes, FSM state type and opcode classification helpers for alu_arbiter
package alu_pkg;
  typedef logic [4:0] alu_op_t;
  localparam alu_op_t ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_MUL = 5'd3, ALU_MOV = 5'd4, ALU_DIV = 5'd5;
  localparam alu_op_t ALU_AND = 5'd9, ALU_OR = 5'd10, ALU_XOR = 5'd11, ALU_NOT = 5'd12;
  localparam alu_op_t ALU_LDR = 5'd17, ALU_STR = 5'd19;
  localparam alu_op_t ALU_JE = 5'd25, ALU_JNE = 5'd26, ALU_JLT = 5'd27, ALU_JGT = 5'd28, ALU_JGE = 5'd29, ALU_JLE = 5'd30;
  typedef enum logic {IDLE, EXEC} arb_state_t;
  function automatic logic is_multicycle(alu_op_t op);
    return op == ALU_MUL || op == ALU_DIV;
  endfunction
  function automatic logic is_legal(alu_op_t op);
    return op inside {[ALU_ADD:ALU_DIV], [ALU_AND:ALU_NOT], ALU_LDR, ALU_STR, [ALU_JE:ALU_JLE]};
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side request/response bus of alu_arbiter
interface alu_arbiter_if #(parameter int N = 8, parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ*5-1:0] req_ctrl;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [N-1:0] rsp_data;
  logic rsp_err;
  modport master(output req_valid, req_ctrl, req_a, req_b, input req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave(input req_valid, req_ctrl, req_a, req_b, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, searching upward from last+1
module rr_arbiter #(parameter int NREQ = 2) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         grant
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] idx;
  // farthest candidate first so the nearest valid one overwrites it
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      grant = req[idx] ? NREQ'(1) << idx : grant;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
// Optional opcode check enabled by defining ALU_ARB_OPCHK_EN.
module alu_arbiter import alu_pkg::*; #(
  parameter int N = 8,
  parameter int NREQ = 2,
  parameter int MULDIV_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output alu_op_t       alu_ctrl,
  output logic [N-1:0]  src_A,
  output logic [N-1:0]  src_B,
  input  logic [N-1:0]  alu_result
);
  localparam int IW = $clog2(NREQ);
  arb_state_t state, state_nx;
  logic [IW-1:0] last, id, win;
  logic [NREQ-1:0] grant, rsp_valid;
  alu_op_t op, sel_op;
  logic [N-1:0] a, b, rsp_data;
  logic [3:0] cnt;
  logic hs, done, legal, rsp_err;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req_valid), .last(last), .grant(grant));
  assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign hs = |bus.req_ready;
  assign done = state == EXEC && cnt == '0;
  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) win = grant[i] ? IW'(i) : win;
  end
  assign sel_op = bus.req_ctrl[5*int'(win) +: 5];
`ifdef ALU_ARB_OPCHK_EN
  assign legal = is_legal(op);
`else
  assign legal = 1'b1;
`endif
  // illegal ops keep the ALU on its zero-output default while still taking one EXEC cycle
  assign alu_ctrl = (state == EXEC && legal) ? op : '0;
  assign src_A = state == EXEC ? a : '0;
  assign src_B = state == EXEC ? b : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data = rsp_data;
  assign bus.rsp_err = rsp_err;
  always_comb state_nx = state == IDLE ? (hs ? EXEC : IDLE) : (done ? IDLE : EXEC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(NREQ - 1);
      id <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (hs) begin
        last <= win;
        id <= win;
        op <= sel_op;
        a <= bus.req_a[N*int'(win) +: N];
        b <= bus.req_b[N*int'(win) +: N];
        cnt <= is_multicycle(sel_op) ? 4'(MULDIV_LAT - 1) : '0;
      end else if (state == EXEC) cnt <= cnt - 1'b1;
      if (done) begin
        rsp_valid <= NREQ'(1) << id;
        rsp_data <= legal ? alu_result : '0;
        rsp_err <= !legal;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_alu_arbiter;
  localparam int N = 8, NREQ = 2, LAT = 3;
`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_arbiter_if #(.N(N), .NREQ(NREQ)) bus();
  logic [4:0] alu_ctrl;
  logic [N-1:0] src_A, src_B, alu_result;
  alu_arbiter #(.N(N), .NREQ(NREQ), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .alu_ctrl(alu_ctrl),
    .src_A(src_A), .src_B(src_B), .alu_result(alu_result));
  function automatic logic [N-1:0] alu_f(logic [4:0] op, logic [N-1:0] x, logic [N-1:0] y);
    case (op)
      5'd1, 5'd17, 5'd19: return x + y;
      5'd2: return x - y;
      5'd3: return x * y;
      5'd4: return x;
      5'd5: return y == 0 ? '0 : x / y;
      5'd9: return x & y;
      5'd10: return x | y;
      5'd11: return x ^ y;
      5'd12: return ~x;
      5'd25: return N'(x == y);
      5'd26: return N'(x != y);
      5'd27: return N'(x < y);
      5'd28: return N'(x > y);
      5'd29: return N'(x >= y);
      5'd30: return N'(x <= y);
      default: return '0;
    endcase
  endfunction
  always_comb alu_result = alu_f(alu_ctrl, src_A, src_B);
  function automatic bit legal_op(logic [4:0] op);
    return (op >= 1 && op <= 5) || (op >= 9 && op <= 12) || op == 17 || op == 19 || (op >= 25 && op <= 30);
  endfunction
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_req(input int r, input logic [4:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    bus.req_ctrl[5*r +: 5] = op;
    bus.req_a[N*r +: N] = x;
    bus.req_b[N*r +: N] = y;
  endtask
  // transaction-level reference: round-robin pick, busy window and due cycle of each response
  typedef struct {int id; logic [4:0] op; logic [N-1:0] a, b; int due;} txn_t;
  txn_t q[$];
  int cyc = 0, last_m = NREQ - 1, free_at = 0;
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int w;
    txn_t t;
    bit ok;
    cyc++;
    if (!rst_n) begin
      q.delete();
      last_m = NREQ - 1;
      free_at = 0;
    end else begin
      er = '0;
      w = -1;
      if (cyc >= free_at)
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && bus.req_valid[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
      if (w >= 0) er[w] = 1'b1;
      chk("m_ready", 32'(bus.req_ready), 32'(er));
      if (q.size() > 0 && cyc < q[0].due) begin
        ok = !OPCHK || legal_op(q[0].op);
        chk("m_alu_ctrl", 32'(alu_ctrl), ok ? 32'(q[0].op) : 32'd0);
        chk("m_src_a", 32'(src_A), 32'(q[0].a));
        chk("m_src_b", 32'(src_B), 32'(q[0].b));
      end else chk("m_idle_alu", {alu_ctrl, src_A, src_B}, 32'd0);
      if (q.size() > 0 && q[0].due == cyc) begin
        ok = !OPCHK || legal_op(q[0].op);
        chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(1) << q[0].id);
        chk("m_rsp_data", 32'(bus.rsp_data), ok ? 32'(alu_f(q[0].op, q[0].a, q[0].b)) : 32'd0);
        chk("m_rsp_err", 32'(bus.rsp_err), 32'(!ok));
        void'(q.pop_front());
      end else chk("m_rsp_idle", 32'(bus.rsp_valid), 32'd0);
      if (w >= 0) begin
        t.id = w;
        t.op = bus.req_ctrl[5*w +: 5];
        t.a = bus.req_a[N*w +: N];
        t.b = bus.req_b[N*w +: N];
        t.due = cyc + ((t.op == 5'd3 || t.op == 5'd5) ? 1 + LAT : 2);
        q.push_back(t);
        last_m = w;
        free_at = t.due;
      end
    end
  end
  typedef struct {int r; logic [4:0] op; logic [N-1:0] a, b, d; bit e; int lat;} vec_t;
  vec_t vt[12];
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, lat, hold, gcnt, prev, prevc, g;
    bit got;
    vt[0] = '{0, 5'd1, 8'd5, 8'd7, 8'd12, 1'b0, 2};
    vt[1] = '{1, 5'd3, 8'd6, 8'd7, 8'd42, 1'b0, 4};
    vt[2] = '{0, 5'd2, 8'd9, 8'd4, 8'd5, 1'b0, 2};
    vt[3] = '{1, 5'd9, 8'hF0, 8'h3C, 8'h30, 1'b0, 2};
    vt[4] = '{0, 5'd11, 8'hFF, 8'h0F, 8'hF0, 1'b0, 2};
    vt[5] = '{1, 5'd5, 8'd100, 8'd7, 8'd14, 1'b0, 4};
    vt[6] = '{0, 5'd7, 8'd5, 8'd6, 8'd0, 1'b1, 2};
    vt[7] = '{1, 5'd1, 8'd200, 8'd100, 8'd44, 1'b0, 2};
    vt[8] = '{0, 5'd3, 8'd16, 8'd17, 8'd16, 1'b0, 4};
    vt[9] = '{1, 5'd0, 8'd3, 8'd3, 8'd0, 1'b1, 2};
    vt[10] = '{0, 5'd25, 8'd4, 8'd4, 8'd1, 1'b0, 2};
    vt[11] = '{1, 5'd12, 8'h0F, 8'd1, 8'hF0, 1'b0, 2};
    bus.req_valid = '0;
    bus.req_ctrl = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    chk("rst_alu", {alu_ctrl, src_A, src_B}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (vt[i]) begin
      @(posedge clk);
      #1 set_req(vt[i].r, vt[i].op, vt[i].a, vt[i].b);
      bus.req_valid = NREQ'(1) << vt[i].r;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        got = bus.req_ready[vt[i].r];
      end
      chk("vec_grant", 32'(got), 1);
      @(posedge clk);
      #1 bus.req_valid = '0;
      lat = 0;
      hold = 0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        lat++;
        if (alu_ctrl == ((OPCHK && vt[i].e) ? 5'd0 : vt[i].op) && src_A == vt[i].a && src_B == vt[i].b) hold++;
        got = bus.rsp_valid != 0;
      end
      chk("vec_latency", 32'(lat), 32'(vt[i].lat));
      chk("vec_hold", 32'(hold), 32'(vt[i].lat - 1));
      chk("vec_rsp_valid", 32'(bus.rsp_valid), 32'(1) << vt[i].r);
      chk("vec_rsp_data", 32'(bus.rsp_data), 32'(vt[i].d));
      chk("vec_rsp_err", 32'(bus.rsp_err), 32'(OPCHK && vt[i].e));
    end
    // both requesters hammering SUB 9-4: strict alternation starting after the last winner (1)
    @(posedge clk);
    #1 set_req(0, 5'd2, 8'd9, 8'd4);
    set_req(1, 5'd2, 8'd9, 8'd4);
    bus.req_valid = 2'b11;
    gcnt = 0;
    prev = -1;
    prevc = 0;
    for (int c = 0; c < 20 && gcnt < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 0) chk("alt_data", 32'(bus.rsp_data), 5);
      if (bus.req_ready != 0) begin
        g = bus.req_ready[1] ? 1 : 0;
        if (gcnt == 0) chk("alt_first", 32'(g), 0);
        else begin
          chk("alt_grant", 32'(g), 32'(1 - prev));
          chk("alt_gap", 32'(c - prevc), 2);
        end
        prev = g;
        prevc = c;
        gcnt++;
      end
    end
    chk("alt_count", 32'(gcnt), 4);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (6) @(posedge clk);
    // reset pulsed during MUL EXEC with one cycle left
    #1 set_req(1, 5'd3, 8'd6, 8'd7);
    bus.req_valid = 2'b10;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.req_ready[1];
    end
    chk("rstx_grant", 32'(got), 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstx_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    chk("rstx_alu", {alu_ctrl, src_A, src_B}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstx_no_rsp", 32'(bus.rsp_valid), 0);
    end
    @(posedge clk);
    #1 set_req(0, 5'd1, 8'd1, 8'd1);
    set_req(1, 5'd1, 8'd2, 8'd2);
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("rstx_next_grant", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    // back-to-back: re-accept in the response cycle
    #1 set_req(0, 5'd1, 8'd2, 8'd3);
    bus.req_valid = 2'b01;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.req_ready[0];
    end
    chk("b2b_grant", 32'(got), 1);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.rsp_valid != 0;
    end
    chk("b2b_rsp", 32'(bus.rsp_valid), 32'b01);
    chk("b2b_ready_same", 32'(bus.req_ready), 32'b01);
    lat = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      lat++;
      got = bus.rsp_valid != 0;
    end
    chk("b2b_next_lat", 32'(lat), 2);
    chk("b2b_next_data", 32'(bus.rsp_data), 5);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (6) @(posedge clk);
    // random traffic, checked by the reference model
    for (int c = 0; c < 1500; c++) begin
      #1 bus.req_valid = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) begin
        w = $urandom_range(0, 5);
        set_req(r, $urandom_range(0, 3) == 0 ? 5'($urandom) : (w == 0 ? 5'd1 : w == 1 ? 5'd2 : w == 2 ? 5'd3 : w == 3 ? 5'd5 : w == 4 ? 5'd9 : 5'd11),
                N'($urandom), N'($urandom));
      end
      @(posedge clk);
    end
    #1 bus.req_valid = '0;
    repeat (8) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between NREQ requesters, e.g. the fetch/execute path and the address generator.
- Each requester presents an opcode and two operands with a valid/ready handshake.
- The block grants requesters round-robin, holds the ALU inputs stable for the op's latency, and returns the registered result to the granted requester as a one-cycle pulse.
- Sits between the requesters and the ALU; drives the ALU's alu_ctrl, src_A and src_B and samples its alu_result.

Parameters:
- N, 8, datapath width, matching the ALU's N.
- NREQ, 2, number of requesters, 2..4.
- MULDIV_LAT, 3, cycles the ALU inputs are held for opcodes 3 (MUL) and 5 (DIV), range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_ctrl  in  NREQ*5  packed opcodes; requester i occupies bits [5i+4:5i].
- req_a  in  NREQ*N  packed operand A; requester i occupies bits [Ni+N-1:Ni].
- req_b  in  NREQ*N  packed operand B, same packing as req_a.
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe to the owning requester.
- rsp_data  out  N  result, valid only while rsp_valid is nonzero.
- rsp_err  out  1  illegal-opcode flag, qualified by rsp_valid.
- alu_ctrl  out  5  to the ALU.
- src_A  out  N  to the ALU.
- src_B  out  N  to the ALU.
- alu_result  in  N  from the ALU.

Behaviour:
- Reset is asynchronous on rst_n low; all state clears immediately:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - alu_ctrl=0, src_A=0, src_B=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- Reset asserted mid-operation aborts the op; no response is ever issued for it.
- FSM has two states: IDLE and EXEC.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from last+1 modulo NREQ.
  - req_ready[winner]=1 combinationally, the same cycle; the handshake completes when valid && ready.
  - On handshake: latch opcode, A, B and the winner id; set last=winner; load cnt = lat-1, where lat = MULDIV_LAT for opcodes 3 and 5, else 1; go to EXEC.
  - No valid request: stay in IDLE, req_ready=0.
- EXEC:
  - req_ready=0 for all requesters.
  - alu_ctrl, src_A and src_B are driven from the latched registers and held stable.
  - cnt decrements each cycle.
  - On the cycle cnt==0: register rsp_data<=alu_result, rsp_valid<=onehot(winner), rsp_err as defined under Optional Feature; go to IDLE.
- Outside EXEC, alu_ctrl=0, so the ALU's default case outputs 0; src_A and src_B are driven to 0.
- Latency, handshake at cycle T:
  - Single-cycle op: rsp_valid at T+2.
  - MUL/DIV: rsp_valid at T+1+MULDIV_LAT.
  - Peak throughput is one simple op per 2 cycles.
- rsp_valid lasts exactly one cycle and has no backpressure; the requester must capture it.
- A new handshake may occur in the same cycle rsp_valid is high, because the FSM is back in IDLE.
- Requests are not required to stay stable while unaccepted; the block samples only on the handshake.
- A requester may hold req_valid continuously. Round-robin guarantees no requester waits more than NREQ-1 grants.
- Opcode width is fixed at 5; results are N bits, matching the ALU truncation.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- When defined:
  - Legal opcodes are 1-5, 9-12, 17, 19 and 25-30.
  - An illegal opcode is still granted, but skips EXEC timing: lat=1, and alu_ctrl stays 0 during EXEC.
  - Response carries rsp_data=0 and rsp_err=1.
- When undefined:
  - Every opcode is forwarded to the ALU unchanged with lat=1, except 3 and 5.
  - rsp_err is tied to 0.

Decomposition:
- Package alu_pkg contains:
  - 5-bit opcode localparams: ALU_ADD=1, ALU_SUB=2, ALU_MUL=3, ALU_MOV=4, ALU_DIV=5, ALU_AND=9, ALU_OR=10, ALU_XOR=11, ALU_NOT=12, ALU_LDR=17, ALU_STR=19, ALU_JE=25 .. ALU_JLE=30.
  - The typedef alu_op_t.
  - Functions is_multicycle(op) and is_legal(op).
- Sub-module rr_arbiter: parameter NREQ; inputs req and last; output one-hot grant. It is purely combinational, and the pointer register lives in alu_arbiter.

Test Plan:
- After reset, req0: ADD with A=8'd5, B=8'd7 -> req_ready[0] same cycle; alu_ctrl=1 for 1 cycle; rsp_valid=2'b01 at T+2 with rsp_data=8'd12, rsp_err=0.
- req1: MUL with A=8'd6, B=8'd7, MULDIV_LAT=3 -> src_A=6 and src_B=7 held for exactly 3 cycles; rsp_valid=2'b10 at T+4 with rsp_data=8'd42.
- Both requesters valid continuously with SUB 9-4 -> grants alternate 0,1,0,1; each rsp_data=8'd5; no grant gap longer than 2 cycles.
- Reset pulsed during MUL EXEC, cnt=1 -> all outputs 0 immediately; no rsp_valid afterwards; the next grant goes to requester 0.
- Opcode 5'd7 with ALU_ARB_OPCHK_EN defined -> rsp_valid at T+2, rsp_data=0, rsp_err=1. Without the macro -> rsp_err=0 and rsp_data=0 (ALU default).
- Back-to-back: new req0 valid in the cycle rsp_valid is high -> accepted in that cycle; the next response arrives 2 cycles later.
